// File: rtl/lcd_nibble_writer.sv
// ---------------------------------------------------------------------------
// lcd_nibble_writer
//
// Output stage of the LCD path. Takes one byte (command or data) per
// WR_VALID/WR_READY handshake and writes it to a 4-bit HD44780-style
// character LCD, upper nibble first. The block generates the RS/E/DB timing
// and the post-write execution wait.
//
// Transaction:
//   IDLE -> SETUP_H -> PULSE_H -> HOLD_H -> GAP_ST -> SETUP_L -> PULSE_L
//        -> HOLD_L -> WAIT_ST -> IDLE
// Each timed state lasts exactly its *_CYC parameter. Every parameter must
// be at least 1.
//
// Ports:
//   CCLK      in   system clock
//   RST       in   asynchronous, active-high reset
//   WR_VALID  in   request valid (requester holds it until accepted)
//   WR_RS     in   0 = command, 1 = data
//   WR_DATA   in   [7:0] byte to write
//   WR_READY  out  idle and able to accept
//   BUSY      out  ~WR_READY
//   LCDRS     out  LCD register select
//   LCDRW     out  LCD read/write, tied to 0 (write only)
//   LCDE      out  LCD enable strobe
//   LCDDAT    out  [3:0] LCD data nibble
//
// Optional feature, macro LCD_INIT_EN: when defined, the block runs the
// 4-bit power-on init sequence after reset before raising WR_READY. The
// sequence is 0x3, 0x3, 0x3, 0x2, all with RS=0. When the macro is
// undefined, IDLE is entered on the first edge after reset release.
// ---------------------------------------------------------------------------
module lcd_nibble_writer #(
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 1,
  parameter int GAP_CYC       = 50,
  parameter int CMD_WAIT_CYC  = 2000,
  parameter int LONG_WAIT_CYC = 82000,
  parameter int INIT_WAIT_CYC = 750000,
  parameter int INIT_GAP_CYC  = 205000
) (
  input  logic       CCLK,
  input  logic       RST,
  input  logic       WR_VALID,
  input  logic       WR_RS,
  input  logic [7:0] WR_DATA,
  output logic       WR_READY,
  output logic       BUSY,
  output logic       LCDRS,
  output logic       LCDRW,
  output logic       LCDE,
  output logic [3:0] LCDDAT
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The shared counter only has to hold the largest parameter that is
  // actually used. The init delays count only when the init sequence is
  // built in.
  localparam int MAX_XFER = imax(imax(imax(SETUP_CYC, PULSE_CYC), imax(HOLD_CYC, GAP_CYC)),
                                 imax(CMD_WAIT_CYC, LONG_WAIT_CYC));
`ifdef LCD_INIT_EN
  localparam int MAX_P = imax(MAX_XFER, imax(INIT_WAIT_CYC, INIT_GAP_CYC));
`else
  localparam int MAX_P = MAX_XFER;
`endif
  // The counter holds (cycles - 1), so clog2(MAX_P) bits are enough.
  localparam int CW = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef enum logic [3:0] {
    RESET_ST,
    IDLE,
    SETUP_H,
    PULSE_H,
    HOLD_H,
    GAP_ST,
    SETUP_L,
    PULSE_L,
    HOLD_L,
`ifdef LCD_INIT_EN
    INIT_WAIT,
    I_SETUP,
    I_PULSE,
    I_HOLD,
    I_WAIT,
`endif
    WAIT_ST
  } state_t;

  // Reload value for a state that lasts n cycles. The state exits on the
  // cycle where the counter reads zero.
  function automatic logic [CW-1:0] ld(input int n);
    return CW'(n - 1);
  endfunction

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            rs_q;
  logic [7:0]      data_q;
  logic            ready_q;
  logic            lcdrs_q;
  logic            lcde_q;
  logic [3:0]      lcddat_q;
`ifdef LCD_INIT_EN
  logic [1:0]      step_q;     // index of the current init nibble, 0..3
`endif

  logic            done;
  logic            long_wait;

  assign done = (cnt_q == '0);

  // Clear display (0x01) and return home (0x02/0x03) need the long
  // execution wait. Every other command and all data writes use the short
  // wait.
  assign long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      state_q  <= RESET_ST;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      ready_q  <= 1'b0;
      lcdrs_q  <= 1'b0;
      lcde_q   <= 1'b0;
      lcddat_q <= 4'h0;
`ifdef LCD_INIT_EN
      step_q   <= 2'd0;
`endif
    end else begin
      // A state entry below overrides this decrement with a fresh reload.
      if (!done) cnt_q <= cnt_q - 1'b1;

      case (state_q)
        RESET_ST: begin
`ifdef LCD_INIT_EN
          state_q <= INIT_WAIT;
          cnt_q   <= ld(INIT_WAIT_CYC);
          step_q  <= 2'd0;
`else
          state_q <= IDLE;
          ready_q <= 1'b1;
`endif
        end

        IDLE: begin
          if (WR_VALID) begin
            rs_q     <= WR_RS;
            data_q   <= WR_DATA;
            lcdrs_q  <= WR_RS;
            lcddat_q <= WR_DATA[7:4];
            ready_q  <= 1'b0;
            state_q  <= SETUP_H;
            cnt_q    <= ld(SETUP_CYC);
          end
        end

        SETUP_H: if (done) begin
          state_q <= PULSE_H;
          lcde_q  <= 1'b1;
          cnt_q   <= ld(PULSE_CYC);
        end

        PULSE_H: if (done) begin
          state_q <= HOLD_H;
          lcde_q  <= 1'b0;
          cnt_q   <= ld(HOLD_CYC);
        end

        HOLD_H: if (done) begin
          state_q <= GAP_ST;
          cnt_q   <= ld(GAP_CYC);
        end

        GAP_ST: if (done) begin
          state_q  <= SETUP_L;
          lcddat_q <= data_q[3:0];
          cnt_q    <= ld(SETUP_CYC);
        end

        SETUP_L: if (done) begin
          state_q <= PULSE_L;
          lcde_q  <= 1'b1;
          cnt_q   <= ld(PULSE_CYC);
        end

        PULSE_L: if (done) begin
          state_q <= HOLD_L;
          lcde_q  <= 1'b0;
          cnt_q   <= ld(HOLD_CYC);
        end

        HOLD_L: if (done) begin
          state_q <= WAIT_ST;
          cnt_q   <= long_wait ? ld(LONG_WAIT_CYC) : ld(CMD_WAIT_CYC);
        end

        // READY rises on the exit edge, so a request already held on
        // WR_VALID is taken on the very next edge.
        WAIT_ST: if (done) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end

`ifdef LCD_INIT_EN
        INIT_WAIT: if (done) begin
          state_q  <= I_SETUP;
          lcdrs_q  <= 1'b0;
          lcddat_q <= 4'h3;
          cnt_q    <= ld(SETUP_CYC);
        end

        I_SETUP: if (done) begin
          state_q <= I_PULSE;
          lcde_q  <= 1'b1;
          cnt_q   <= ld(PULSE_CYC);
        end

        I_PULSE: if (done) begin
          state_q <= I_HOLD;
          lcde_q  <= 1'b0;
          cnt_q   <= ld(HOLD_CYC);
        end

        // Only the first 0x3 needs the long 4.1 ms gap. The others use the
        // normal command wait.
        I_HOLD: if (done) begin
          state_q <= I_WAIT;
          cnt_q   <= (step_q == 2'd0) ? ld(INIT_GAP_CYC) : ld(CMD_WAIT_CYC);
        end

        I_WAIT: if (done) begin
          if (step_q == 2'd3) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            step_q   <= step_q + 1'b1;
            // The fourth nibble (step 3) switches the LCD into 4-bit mode.
            lcddat_q <= (step_q == 2'd2) ? 4'h2 : 4'h3;
            state_q  <= I_SETUP;
            cnt_q    <= ld(SETUP_CYC);
          end
        end
`endif

        default: begin
          state_q <= RESET_ST;
          ready_q <= 1'b0;
          lcde_q  <= 1'b0;
        end
      endcase
    end
  end

  assign WR_READY = ready_q;
  assign BUSY     = ~ready_q;
  assign LCDRS    = lcdrs_q;
  assign LCDRW    = 1'b0;
  assign LCDE     = lcde_q;
  assign LCDDAT   = lcddat_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// ---------------------------------------------------------------------------
// Testbench for lcd_nibble_writer. It uses the reduced timing parameters
// below. Each write pushes its two expected nibbles into a queue. A monitor
// pops one entry per E pulse and checks the nibble, RS and the pulse width.
// Define LCD_INIT_EN to cover the power-on init sequence.
// ---------------------------------------------------------------------------
module tb_lcd_nibble_writer;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 1;
  localparam int G  = 3;
  localparam int CW = 10;
  localparam int LW = 20;
  localparam int IW = 30;
  localparam int IG = 15;
  localparam int T_CMD  = 2*(S+P+H) + G + CW;            // 27
  localparam int T_LONG = 2*(S+P+H) + G + LW;            // 37
  localparam int T_INIT = 1 + IW + 4*(S+P+H) + IG + 3*CW; // 104

  logic       CCLK, RST, WR_VALID, WR_RS;
  logic [7:0] WR_DATA;
  logic       WR_READY, BUSY, LCDRS, LCDRW, LCDE;
  logic [3:0] LCDDAT;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct { logic rs; logic [3:0] nib; } exp_t;
  exp_t exp_q[$];

  typedef struct { logic rs; logic [7:0] data; int lat; } vec_t;
  vec_t vecs[8];

  lcd_nibble_writer #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .GAP_CYC(G),
    .CMD_WAIT_CYC(CW), .LONG_WAIT_CYC(LW),
    .INIT_WAIT_CYC(IW), .INIT_GAP_CYC(IG)
  ) dut (
    .CCLK(CCLK), .RST(RST), .WR_VALID(WR_VALID), .WR_RS(WR_RS),
    .WR_DATA(WR_DATA), .WR_READY(WR_READY), .BUSY(BUSY), .LCDRS(LCDRS),
    .LCDRW(LCDRW), .LCDE(LCDE), .LCDDAT(LCDDAT)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge and scores every E pulse.
  initial begin
    logic       prev_e;
    int         width;
    logic [3:0] nib0;
    exp_t       e;
    prev_e = 1'b0;
    width  = 0;
    nib0   = 4'h0;
    forever begin
      @(negedge CCLK);
      if (RST) begin
        prev_e = 1'b0;
        width  = 0;
      end else begin
        check("busy_inv", BUSY, !WR_READY);
        check("rw_zero", LCDRW, 0);
        if (LCDE && !prev_e) begin
          pulses++;
          width = 1;
          nib0  = LCDDAT;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got nibble %0h expected no pulse", LCDDAT);
          end else begin
            e = exp_q.pop_front();
            check("pulse_nib", LCDDAT, e.nib);
            check("pulse_rs", LCDRS, e.rs);
          end
        end else if (LCDE) begin
          width++;
        end else if (prev_e) begin
          check("e_width", width, P);
          check("nib_hold", LCDDAT, nib0);
        end
        prev_e = LCDE;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Counts rising edges until WR_READY is sampled high at a falling edge.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge CCLK);
      n++;
      @(negedge CCLK);
    end while (!WR_READY && n < 2000);
  endtask

  // Called at a falling edge with RST high.
  task automatic release_reset();
    int n;
`ifdef LCD_INIT_EN
    exp_q.push_back('{1'b0, 4'h3});
    exp_q.push_back('{1'b0, 4'h3});
    exp_q.push_back('{1'b0, 4'h3});
    exp_q.push_back('{1'b0, 4'h2});
    // A request held during init must not be taken.
    WR_VALID = 1'b1; WR_RS = 1'b1; WR_DATA = 8'hFF;
    RST = 1'b0;
    wait_ready(n);
    WR_VALID = 1'b0;
    check("init_latency", n, T_INIT);
    check("init_queue_empty", exp_q.size(), 0);
    @(negedge CCLK);
    check("init_still_ready", WR_READY, 1);
`else
    RST = 1'b0;
    #1;
    check("ready_before_edge", WR_READY, 0);
    @(negedge CCLK);
    check("ready_after_release", WR_READY, 1);
`endif
  endtask

  task automatic do_write(input logic rs, input logic [7:0] data, input int lat);
    int n;
    int p0;
    n = 0;
    while (!WR_READY && n < 2000) begin @(negedge CCLK); n++; end
    p0 = pulses;
    WR_VALID = 1'b1; WR_RS = rs; WR_DATA = data;
    exp_q.push_back('{rs, data[7:4]});
    exp_q.push_back('{rs, data[3:0]});
    @(posedge CCLK);
    #1;
    WR_VALID = 1'b0; WR_DATA = ~data; WR_RS = ~rs;
    check("accept_drops_ready", WR_READY, 0);
    wait_ready(n);
    check("write_latency", n, lat);
    check("write_pulses", pulses - p0, 2);
    check("write_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int p0;
    vecs[0] = '{1'b1, 8'h48, T_CMD};
    vecs[1] = '{1'b0, 8'h01, T_LONG};
    vecs[2] = '{1'b0, 8'h02, T_LONG};
    vecs[3] = '{1'b0, 8'h03, T_LONG};
    vecs[4] = '{1'b0, 8'h04, T_CMD};
    vecs[5] = '{1'b0, 8'h00, T_CMD};
    vecs[6] = '{1'b1, 8'h01, T_CMD};
    vecs[7] = '{1'b0, 8'h81, T_CMD};

    RST = 1'b1; WR_VALID = 1'b0; WR_RS = 1'b0; WR_DATA = 8'h00;
    repeat (3) @(negedge CCLK);
    check("rst_lcde", LCDE, 0);
    check("rst_lcdrs", LCDRS, 0);
    check("rst_lcdrw", LCDRW, 0);
    check("rst_lcddat", LCDDAT, 0);
    check("rst_ready", WR_READY, 0);
    check("rst_busy", BUSY, 1);
    release_reset();

    for (int i = 0; i < 8; i++) do_write(vecs[i].rs, vecs[i].data, vecs[i].lat);

    // Back-to-back: WR_VALID stays high and the data changes right after
    // the first accept edge.
    p0 = pulses;
    WR_VALID = 1'b1; WR_RS = 1'b1; WR_DATA = 8'hA5;
    exp_q.push_back('{1'b1, 4'hA});
    exp_q.push_back('{1'b1, 4'h5});
    @(posedge CCLK);
    #1;
    WR_RS = 1'b0; WR_DATA = 8'h3C;
    exp_q.push_back('{1'b0, 4'h3});
    exp_q.push_back('{1'b0, 4'hC});
    wait_ready(n);
    check("b2b_first_latency", n, T_CMD);
    @(posedge CCLK);
    #1;
    WR_VALID = 1'b0;
    check("b2b_second_accepted", WR_READY, 0);
    wait_ready(n);
    check("b2b_second_latency", n, T_CMD);
    check("b2b_pulses", pulses - p0, 4);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Reset during PULSE_L: E must drop without waiting for a clock edge.
    WR_VALID = 1'b1; WR_RS = 1'b1; WR_DATA = 8'h7E;
    exp_q.push_back('{1'b1, 4'h7});
    exp_q.push_back('{1'b1, 4'hE});
    @(posedge CCLK);
    #1;
    WR_VALID = 1'b0;
    repeat (13) @(posedge CCLK);
    @(negedge CCLK);
    check("pulse_l_active", LCDE, 1);
    check("pulse_l_nibble", LCDDAT, 4'hE);
    #1;
    RST = 1'b1;
    #1;
    check("arst_lcde", LCDE, 0);
    check("arst_lcdrs", LCDRS, 0);
    check("arst_lcddat", LCDDAT, 0);
    check("arst_ready", WR_READY, 0);
    check("arst_busy", BUSY, 1);
    exp_q.delete();
    repeat (2) @(negedge CCLK);
    p0 = pulses;
    release_reset();
    repeat (20) @(negedge CCLK);
`ifdef LCD_INIT_EN
    check("no_residual_pulse", pulses - p0, 4);
`else
    check("no_residual_pulse", pulses - p0, 0);
`endif
    do_write(1'b1, 8'h5A, T_CMD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
